spi_regbank_slave: RTL and testbench
====================================

SPI_REGBANK_SLAVE -- requirements
Module: spi_regbank_slave

Interface
REQ-001 Parameter: DATA_W, 8, register width and data-word length in bits.
REQ-002 Parameter: REG_AW, 3, register address width; register count = 2**REG_AW.
REQ-003 Parameter: DEV_AW, 3, device address width.
REQ-004 Parameter: LSB_FIRST, 1, 1 = every field (header and data) shifts LSB first; 0 = MSB first.
REQ-005 Port: sclk  in  1  sole clock; all state updates on the rising edge.
REQ-006 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-007 Port: cs  in  1  chip select, active-high; cs=0 at a sclk edge ends or aborts the frame.
REQ-008 Port: mosi  in  1  serial data in, sampled on the rising sclk edge.
REQ-009 Port: dev_addr  in  DEV_AW  this slave's strapped device address.
REQ-010 Port: miso  out  1  serial read data; 0 whenever miso_oe=0; external tri-state buffer uses miso_oe.
REQ-011 Port: miso_oe  out  1  output enable, high only while this slave owns the bus.
REQ-012 Port: wr_pulse  out  1  one-cycle strobe on each committed register write.
REQ-013 Port: wr_reg_addr  out  REG_AW  address of the last committed write.
REQ-014 Port: wr_data  out  DATA_W  data of the last committed write.
REQ-015 Port: frame_abort  out  1  one-cycle strobe when cs drops with a partial word in flight.

Function
REQ-016 Frame header: WR (1 bit, 1 = write), DEVA (DEV_AW), BURST (1), REGA (REG_AW), in that order; header length H = 2+DEV_AW+REG_AW bits.
REQ-017 Bit order within DEVA, REGA and data follows LSB_FIRST.
REQ-018 FSM states: HDR, DATA, IGNORE; bit counter counts bits within the current field group.
REQ-019 Any edge with cs=0: state->HDR, counter->0, miso_oe->0, no register change.
REQ-020 HDR: capture one header bit per edge; on edge capturing bit H-1: DEVA==dev_addr -> DATA, else IGNORE.
REQ-021 IGNORE: miso_oe=0, registers untouched, stay until cs=0.
REQ-022 Read, on the HDR->DATA edge: load shift register with reg[REGA]; set miso_oe=1; miso presents the first data bit before the next edge.
REQ-023 Read DATA: each edge shifts out the next bit; reads are non-destructive; register contents unchanged.
REQ-024 Write DATA: shift mosi into a shadow word; miso_oe=1, miso=0; reg[REGA] updated only on the edge capturing data bit DATA_W-1.
REQ-025 Write commit: wr_pulse=1 for exactly the next cycle, with wr_reg_addr and wr_data valid while wr_pulse=1.
REQ-026 Word boundary with BURST=1: REGA increments modulo 2**REG_AW (wraps 2**REG_AW-1 -> 0); reads reload the shift register from the new address on the same edge, with no gap bit.
REQ-027 Word boundary with BURST=0: further bits are ignored until cs=0; miso_oe->0.
REQ-028 cs=0 with 1..DATA_W-1 data bits of a write word shifted: shadow discarded, frame_abort=1 for one cycle; completed words stay committed.
REQ-029 A write to register r followed in the same burst by a read is not possible; a later read frame of r returns the committed value.

Reset
REQ-030 Edge with rst_n=0 (overrides cs): all 2**REG_AW registers->0; state->HDR; counter->0; miso=0; miso_oe=0; wr_pulse=0; wr_reg_addr=0; wr_data=0; frame_abort=0.
REQ-031 Reset mid-frame: the in-flight word is discarded without wr_pulse or frame_abort; the first edge after release with cs=1 samples header bit 0.

Structure
REQ-032 Package spi_regbank_pkg holds the FSM state enum and header field-offset localparams derived from DEV_AW/REG_AW.
REQ-033 One sub-module, spi_shift_word: DATA_W-bit load/shift register with LSB_FIRST select, shared by the read and write paths.

Verification (DATA_W=8, REG_AW=3, DEV_AW=3, LSB_FIRST=1, dev_addr=3'd5)
REQ-034 Write frame WR=1, DEVA=5, BURST=0, REGA=2, data 8'hA5 -> reg[2]=8'hA5; wr_pulse one cycle with addr 2, data 8'hA5; miso_oe=1 during data.
REQ-035 Read frame REGA=2 after REQ-034 -> miso emits A5 LSB first over 8 edges; second identical read again returns 8'hA5.
REQ-036 Burst write REGA=7, words 8'h11, 8'h22 -> reg[7]=8'h11, reg[0]=8'h22 (wrap); two wr_pulses.
REQ-037 Frame with DEVA=3 -> miso_oe stays 0, no wr_pulse, all registers unchanged.
REQ-038 Write frame, cs dropped after 4 data bits -> frame_abort one cycle, target register unchanged; next frame decodes normally.
REQ-039 rst_n=0 for one edge mid-burst read -> miso_oe=0, all registers 0, following read returns 8'h00.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// Shared types and header-layout helpers for the SPI register-bank slave.
// Header bit order: WR, DEVA[DEV_AW], BURST, REGA[REG_AW].
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        ST_HDR    = 2'd0,
        ST_DATA   = 2'd1,
        ST_IGNORE = 2'd2
    } spi_state_t;

    localparam int OFF_WR   = 0;
    localparam int OFF_DEVA = 1;

    function automatic int off_burst(input int dev_aw);
        return OFF_DEVA + dev_aw;
    endfunction

    function automatic int off_rega(input int dev_aw);
        return OFF_DEVA + dev_aw + 1;
    endfunction

    function automatic int hdr_len(input int dev_aw, input int reg_aw);
        return 2 + dev_aw + reg_aw;
    endfunction

endpackage

// File: rtl/spi_regbank_slave_shift.sv
// DATA_W-bit load/shift word used both to serialise read data and to collect write data.
// o_next is the value the word takes on this edge, so a completed write can be committed at once.
module spi_shift_word
    import spi_regbank_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic              i_clk,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic              i_shift,
    input  logic              i_shin,
    output logic [DATA_W-1:0] o_next,
    output logic              o_sout
);

    logic [DATA_W-1:0] r_q;

    always_comb begin
        o_next = r_q;
        if (i_load) begin
            o_next = i_load_val;
        end else if (i_shift) begin
            if (LSB_FIRST != 0) o_next = DATA_W'({i_shin, r_q} >> 1);
            else                o_next = DATA_W'({r_q, i_shin});
        end
    end

    always_ff @(posedge i_clk) begin
        r_q <= o_next;
    end

    assign o_sout = (LSB_FIRST != 0) ? r_q[0] : r_q[DATA_W-1];

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI slave with a 2**REG_AW x DATA_W register bank, device-address match and burst access.
// Everything runs on sclk; cs low at an edge returns the slave to header decode.
module spi_regbank_slave
    import spi_regbank_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int REG_AW    = 3,
    parameter int DEV_AW    = 3,
    parameter int LSB_FIRST = 1
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              mosi,
    input  logic [DEV_AW-1:0] dev_addr,
    output logic              miso,
    output logic              miso_oe,
    output logic              wr_pulse,
    output logic [REG_AW-1:0] wr_reg_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_abort
);

    localparam int H       = hdr_len(DEV_AW, REG_AW);
    localparam int OB      = off_burst(DEV_AW);
    localparam int OR      = off_rega(DEV_AW);
    localparam int CNT_MAX = (H > DATA_W) ? H : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int NREGS   = 1 << REG_AW;

    spi_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr;
    logic              r_burst;
    logic              r_oe;
    logic [DEV_AW-1:0] r_deva;
    logic [REG_AW-1:0] r_rega;
    logic [DATA_W-1:0] r_regs [0:NREGS-1];
    logic              r_wr_pulse;
    logic              r_abort;
    logic [REG_AW-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [DEV_AW-1:0] w_deva;
    logic [REG_AW-1:0] w_rega;
    logic [REG_AW-1:0] w_rega_inc;
    logic              w_hdr_last;
    logic              w_word_last;
    logic              w_load;
    logic              w_shift;
    logic [DATA_W-1:0] w_load_val;
    logic [DATA_W-1:0] w_word_next;
    logic              w_sout;

    // Address fields are collected serially in the same bit order as data words.
    always_comb begin
        w_deva = r_deva;
        w_rega = r_rega;
        if (r_cnt >= CNT_W'(OFF_DEVA) && r_cnt < CNT_W'(OB)) begin
            if (LSB_FIRST != 0) w_deva = DEV_AW'({mosi, r_deva} >> 1);
            else                w_deva = DEV_AW'({r_deva, mosi});
        end
        if (r_cnt >= CNT_W'(OR)) begin
            if (LSB_FIRST != 0) w_rega = REG_AW'({mosi, r_rega} >> 1);
            else                w_rega = REG_AW'({r_rega, mosi});
        end
    end

    assign w_rega_inc  = r_rega + REG_AW'(1);
    assign w_hdr_last  = (r_state == ST_HDR)  && (r_cnt == CNT_W'(H - 1));
    assign w_word_last = (r_state == ST_DATA) && (r_cnt == CNT_W'(DATA_W - 1));

    // Reads reload at the header end and at each burst word boundary, so no gap bit appears.
    assign w_load     = rst_n && cs && !r_wr &&
                        ((w_hdr_last && (w_deva == dev_addr)) || (w_word_last && r_burst));
    assign w_shift    = rst_n && cs && (r_state == ST_DATA) && !w_load;
    assign w_load_val = w_hdr_last ? r_regs[w_rega] : r_regs[w_rega_inc];

    spi_shift_word #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .i_clk      (sclk),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_shift    (w_shift),
        .i_shin     (mosi),
        .o_next     (w_word_next),
        .o_sout     (w_sout)
    );

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_state    <= ST_HDR;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_burst    <= 1'b0;
            r_oe       <= 1'b0;
            r_deva     <= '0;
            r_rega     <= '0;
            r_wr_pulse <= 1'b0;
            r_abort    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_pulse <= 1'b0;
            r_abort    <= 1'b0;
            if (!cs) begin
                r_state <= ST_HDR;
                r_cnt   <= '0;
                r_oe    <= 1'b0;
                if (r_state == ST_DATA && r_wr && r_cnt != '0) r_abort <= 1'b1;
            end else begin
                case (r_state)
                    ST_HDR: begin
                        if (r_cnt == CNT_W'(OFF_WR)) r_wr    <= mosi;
                        if (r_cnt == CNT_W'(OB))     r_burst <= mosi;
                        r_deva <= w_deva;
                        r_rega <= w_rega;
                        if (w_hdr_last) begin
                            r_cnt <= '0;
                            if (w_deva == dev_addr) begin
                                r_state <= ST_DATA;
                                r_oe    <= 1'b1;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (w_word_last) begin
                            r_cnt <= '0;
                            if (r_wr) begin
                                r_regs[r_rega] <= w_word_next;
                                r_wr_pulse     <= 1'b1;
                                r_wr_addr      <= r_rega;
                                r_wr_data      <= w_word_next;
                            end
                            if (r_burst) begin
                                r_rega <= w_rega_inc;
                            end else begin
                                r_state <= ST_IGNORE;
                                r_oe    <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_IGNORE: ;
                    default: r_state <= ST_HDR;
                endcase
            end
        end
    end

    assign miso        = r_oe && !r_wr && w_sout;
    assign miso_oe     = r_oe;
    assign wr_pulse    = r_wr_pulse;
    assign wr_reg_addr = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Randomised bench for spi_regbank_slave against a frame-level register-bank model.
module tb_spi_regbank_slave;

    localparam logic [2:0] DEV = 3'd5;

    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       mosi = 1'b0;
    logic [2:0] dev_addr = DEV;
    logic       miso;
    logic       miso_oe;
    logic       wr_pulse;
    logic [2:0] wr_reg_addr;
    logic [7:0] wr_data;
    logic       frame_abort;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mregs [8];
    logic [7:0] wdat  [16];

    spi_regbank_slave #(
        .DATA_W(8), .REG_AW(3), .DEV_AW(3), .LSB_FIRST(1)
    ) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .cs          (cs),
        .mosi        (mosi),
        .dev_addr    (dev_addr),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .wr_pulse    (wr_pulse),
        .wr_reg_addr (wr_reg_addr),
        .wr_data     (wr_data),
        .frame_abort (frame_abort)
    );

    always #5 sclk = ~sclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic edge_drive(input bit c, input bit m, input bit r);
        @(negedge sclk);
        cs = c;
        mosi = m;
        rst_n = r;
        @(posedge sclk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_oe"}, miso_oe, 0);
        chk({tag, "_miso"}, miso, 0);
        chk({tag, "_pulse"}, wr_pulse, 0);
        chk({tag, "_waddr"}, wr_reg_addr, 0);
        chk({tag, "_wdata"}, wr_data, 0);
        chk({tag, "_abort"}, frame_abort, 0);
    endtask

    // One frame: header, nbits data edges, then a cs-low edge; rst_at >= 0 resets at that data bit.
    task automatic frame(input bit wr, input bit [2:0] deva, input bit burst,
                         input bit [2:0] rega, input int nbits, input int rst_at);
        bit         match;
        bit [7:0]   hb;
        logic [2:0] addr;
        int         w, b;
        bit         m, exp_oe, exp_miso, exp_pulse, exp_abort;
        match = (deva == DEV);
        hb = {rega, burst, deva, wr};
        for (int i = 0; i < 8; i++) begin
            edge_drive(1'b1, hb[i], 1'b1);
            chk("hdr_pulse", wr_pulse, 0);
            chk("hdr_abort", frame_abort, 0);
            if (i < 7) chk("hdr_oe", miso_oe, 0);
        end
        chk("hdr_end_oe", miso_oe, match);
        exp_miso = match && !wr && mregs[rega][0];
        chk("first_miso", miso, exp_miso);
        for (int k = 0; k < nbits; k++) begin
            w = k / 8;
            b = k % 8;
            addr = rega + 3'(w);
            if (k == rst_at) begin
                edge_drive(1'b1, 1'($urandom), 1'b0);
                for (int r = 0; r < 8; r++) mregs[r] = 8'h00;
                check_idle_outputs("midrst");
                return;
            end
            m = wr ? wdat[w][b] : 1'($urandom);
            edge_drive(1'b1, m, 1'b1);
            exp_pulse = match && wr && (b == 7) && (burst || w == 0);
            chk("data_pulse", wr_pulse, exp_pulse);
            if (exp_pulse) begin
                chk("wr_addr", wr_reg_addr, addr);
                chk("wr_data", wr_data, wdat[w]);
                mregs[addr] = wdat[w];
            end
            exp_oe = match && (burst || (w == 0 && b < 7));
            chk("data_oe", miso_oe, exp_oe);
            exp_miso = 1'b0;
            if (exp_oe && !wr) begin
                if (b < 7) exp_miso = mregs[addr][b + 1];
                else       exp_miso = mregs[addr + 3'd1][0];
            end
            chk("data_miso", miso, exp_miso);
        end
        edge_drive(1'b0, 1'b0, 1'b1);
        exp_abort = match && wr && (nbits % 8 != 0) && (burst || nbits < 8);
        chk("end_abort", frame_abort, exp_abort);
        chk("end_oe", miso_oe, 0);
        chk("end_pulse", wr_pulse, 0);
    endtask

    initial begin
        bit [2:0] d;
        int nb;
        for (int r = 0; r < 8; r++) mregs[r] = 8'h00;
        edge_drive(1'b0, 1'b0, 1'b0);
        edge_drive(1'b1, 1'b1, 1'b0);
        check_idle_outputs("reset");

        wdat[0] = 8'hA5;
        frame(1'b1, DEV, 1'b0, 3'd2, 8, -1);
        frame(1'b0, DEV, 1'b0, 3'd2, 8, -1);
        frame(1'b0, DEV, 1'b0, 3'd2, 8, -1);

        wdat[0] = 8'h11;
        wdat[1] = 8'h22;
        frame(1'b1, DEV, 1'b1, 3'd7, 16, -1);
        frame(1'b0, DEV, 1'b1, 3'd7, 16, -1);

        wdat[0] = 8'hFF;
        frame(1'b1, 3'd3, 1'b0, 3'd2, 8, -1);
        frame(1'b0, 3'd3, 1'b1, 3'd2, 16, -1);

        wdat[0] = 8'h3C;
        frame(1'b1, DEV, 1'b0, 3'd4, 4, -1);
        frame(1'b0, DEV, 1'b0, 3'd4, 12, -1);
        frame(1'b1, DEV, 1'b0, 3'd4, 8, -1);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 16; i++) wdat[i] = 8'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 3'($urandom) : DEV;
            nb = $urandom_range(1, 3) * 8;
            if ($urandom_range(0, 2) == 0) nb = nb - $urandom_range(1, 7);
            frame(1'($urandom), d, 1'($urandom), 3'($urandom), nb, -1);
        end

        frame(1'b0, DEV, 1'b1, 3'd0, 72, -1);

        frame(1'b0, DEV, 1'b1, 3'd0, 24, 10);
        frame(1'b0, DEV, 1'b0, 3'd2, 8, -1);
        frame(1'b0, DEV, 1'b1, 3'd0, 64, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
